bit_ctrl_deadtime: RTL

Break-before-make output stage placed directly downstream of the 6-step `bit_ctrl` pattern sequencer, between its 8-bit pattern output and the pads. Any bit that turns off does so immediately. Any bit that turns on is held low for a programmable dead-time window first, so two drive lines never overlap during a step transition. The block also reports when a window is active and counts committed pattern changes.

---
 rtl/bit_ctrl_deadtime.sv | 96 +++++++++
 1 files changed

// File: rtl/bit_ctrl_deadtime.sv
// Break-before-make output stage: turn-offs pass straight through, turn-ons wait
// out a DEAD_CYCLES window, and committed pattern changes are counted.
module bit_ctrl_deadtime #(
  parameter int WIDTH       = 8,
  parameter int DEAD_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] pat_in,
  output logic [WIDTH-1:0] out_drv,
  output logic             busy,
  output logic [7:0]       change_cnt
);

  localparam logic [7:0] DEAD_LOAD = 8'(DEAD_CYCLES - 1);

  typedef enum logic {IDLE, DEAD} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cur_q, cur_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [7:0]       timer_q, timer_d;
  logic             busy_q, busy_d;
  logic [7:0]       cnt_q, cnt_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cur_q   <= '0;
      tgt_q   <= '0;
      out_q   <= '0;
      timer_q <= '0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      tgt_q   <= tgt_d;
      out_q   <= out_d;
      timer_q <= timer_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    tgt_d   = tgt_q;
    out_d   = out_q;
    timer_d = timer_q;
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (pat_in != cur_q) begin
          if ((pat_in & ~cur_q) == '0) begin
            out_d = pat_in;
            cur_d = pat_in;
            cnt_d = cnt_q + 8'd1;
          end else begin
            // Keep only bits that stay on; new bits wait for the window.
            out_d   = cur_q & pat_in;
            tgt_d   = pat_in;
            timer_d = DEAD_LOAD;
            busy_d  = 1'b1;
            state_d = DEAD;
          end
        end
      end
      DEAD: begin
        if (pat_in != tgt_q) begin
          // Retarget drops any bit no longer requested and restarts the window.
          tgt_d   = pat_in;
          out_d   = out_q & pat_in;
          timer_d = DEAD_LOAD;
        end else if (timer_q != 8'd0) begin
          timer_d = timer_q - 8'd1;
        end else begin
          out_d   = tgt_q;
          cur_d   = tgt_q;
          cnt_d   = cnt_q + 8'd1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign out_drv    = out_q;
  assign busy       = busy_q;
  assign change_cnt = cnt_q;

endmodule
